// File: rtl/mux_pipeline_stream.sv
// mux_pipeline_stream: N:1 multiplexer built as a registered radix-R select tree.
// Every beat carries its own select value. Stages move on a valid/ready back-chain,
// so empty stages fill while the output is stalled and no beat is dropped.
module mux_pipeline_stream #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned INPUT_COUNT = 10,
    parameter int unsigned RADIX       = 4,
    localparam int unsigned SEL_W      = $clog2(INPUT_COUNT),
    localparam int unsigned RB         = $clog2(RADIX),
    localparam int unsigned LEVELS     = (SEL_W + RB - 1) / RB,
    localparam int unsigned OCC_W      = $clog2(LEVELS + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SEL_W-1:0]             in_sel,
    input  logic [WIDTH*INPUT_COUNT-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_err,
    output logic [OCC_W-1:0]             occupancy
);

    // Select padded to a whole number of RB-bit groups; the extra top bits are zero.
    localparam int unsigned SEL_PW = LEVELS * RB;

    // Node count of tree level lvl: ceil(INPUT_COUNT / RADIX^(lvl+1)).
    function automatic int unsigned node_cnt(input int unsigned lvl);
        int unsigned n;
        n = INPUT_COUNT;
        for (int unsigned i = 0; i <= lvl; i++) begin
            n = (n + RADIX - 1) / RADIX;
        end
        return n;
    endfunction

    logic [LEVELS-1:0] v_q, v_d;
    logic [LEVELS-1:0] err_q, err_d;
    logic [LEVELS-1:0] en;
    logic [LEVELS-1:0] up_v;
    logic [LEVELS-1:0] up_err;
    logic [LEVELS-1:0] ld;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [SEL_PW-1:0] sel_pad;
    logic              sel_err;

    assign sel_pad = SEL_PW'(in_sel);
    assign sel_err = (32'(in_sel) >= INPUT_COUNT);

    // Stage enables: a stage may load if it is empty or the stage after it moves.
    always_comb begin
        en = '0;
        en[LEVELS-1] = !v_q[LEVELS-1] | out_ready;
        for (int k = int'(LEVELS) - 2; k >= 0; k--) begin
            en[k] = !v_q[k] | en[k+1];
        end
    end

    // Next-state for valid/err bits; data and sel load only when a real beat arrives.
    always_comb begin
        up_v      = '0;
        up_err    = '0;
        up_v[0]   = in_valid;
        up_err[0] = sel_err;
        for (int k = 1; k < int'(LEVELS); k++) begin
            up_v[k]   = v_q[k-1];
            up_err[k] = err_q[k-1];
        end
        ld    = en & up_v;
        v_d   = '0;
        err_d = '0;
        occ_d = '0;
        for (int k = 0; k < int'(LEVELS); k++) begin
            v_d[k]   = en[k] ? up_v[k] : v_q[k];
            err_d[k] = ld[k] ? up_err[k] : err_q[k];
            occ_d    = occ_d + OCC_W'(v_d[k]);
        end
    end

    // Valid, err and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            err_q <= '0;
            occ_q <= '0;
        end else begin
            v_q   <= v_d;
            err_q <= err_d;
            occ_q <= occ_d;
        end
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int unsigned DstN   = node_cnt(k);
        localparam int unsigned SrcW   = RADIX * DstN * WIDTH;
        localparam int unsigned SelInW = SEL_PW - k * RB;

        // src is zero-extended so children past the last real source read as zero.
        logic [SrcW-1:0]         src;
        logic [SelInW-1:0]       sel_in;
        logic [DstN*WIDTH-1:0]   data_d, data_q;

        if (k == 0) begin : g_src
            assign src    = SrcW'(in_data);
            assign sel_in = sel_pad;
        end else begin : g_src
            assign src    = SrcW'(g_lvl[k-1].data_q);
            assign sel_in = g_lvl[k-1].g_sel.sel_q;
        end

        // Each node picks one of RADIX children with the low RB bits of the select.
        always_comb begin
            data_d = data_q;
            if (ld[k]) begin
                for (int j = 0; j < int'(DstN); j++) begin
                    data_d[j*WIDTH +: WIDTH] =
                        src[(j*RADIX + int'(sel_in[RB-1:0]))*WIDTH +: WIDTH];
                end
            end
        end

        // Node output registers for this level.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end

        // Remaining select bits travel with the beat; the last level needs none.
        if (k < LEVELS - 1) begin : g_sel
            logic [SelInW-RB-1:0] sel_d, sel_q;

            // Capture the select groups still to be consumed downstream.
            always_comb begin
                sel_d = sel_q;
                if (ld[k]) begin
                    sel_d = sel_in[SelInW-1:RB];
                end
            end

            // Select register for this level.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sel_q <= '0;
                end else begin
                    sel_q <= sel_d;
                end
            end
        end
    end

    assign in_ready  = en[0];
    assign out_valid = v_q[LEVELS-1];
    assign out_err   = err_q[LEVELS-1];
    assign out_data  = err_q[LEVELS-1] ? '0 : g_lvl[LEVELS-1].data_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_mux_pipeline_stream.sv
// Directed bench for mux_pipeline_stream (default build) plus a scoreboarded
// random-handshake run on a 37-input radix-2 build.
module tb_mux_pipeline_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Default build: WIDTH=8, INPUT_COUNT=10, RADIX=4 -> LEVELS=2.
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
    logic [3:0]  a_in_sel;
    logic [79:0] a_in_data;
    logic [7:0]  a_out_data;
    logic [1:0]  a_occ;

    // Wide build: WIDTH=5, INPUT_COUNT=37, RADIX=2 -> LEVELS=6.
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
    logic [5:0]   b_in_sel;
    logic [184:0] b_in_data;
    logic [4:0]   b_out_data;
    logic [2:0]   b_occ;

    mux_pipeline_stream dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_sel    (a_in_sel),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_err   (a_out_err),
        .occupancy (a_occ)
    );

    mux_pipeline_stream #(
        .WIDTH       (5),
        .INPUT_COUNT (37),
        .RADIX       (2)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_sel    (b_in_sel),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_err   (b_out_err),
        .occupancy (b_occ)
    );

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Burst table for back-to-back tests on dut_a.
    int unsigned bs_sel[16];
    logic [7:0]  bs_dat[16];
    logic        bs_err[16];

    // Send n beats back-to-back with out_ready high; beat i appears after step i+1.
    task automatic burst(input string tag, input int n);
        for (int i = 0; i <= n; i++) begin
            a_in_valid = (i < n);
            if (i < n) begin
                a_in_sel = 4'(bs_sel[i]);
                check({tag, "_in_ready"}, 32'(a_in_ready), 32'd1);
            end
            step();
            if (i == 0) begin
                check({tag, "_first_valid_early"}, 32'(a_out_valid), 32'd0);
            end else begin
                check({tag, "_valid"}, 32'(a_out_valid), 32'd1);
                check({tag, "_data"}, 32'(a_out_data), 32'(bs_dat[i-1]));
                check({tag, "_err"}, 32'(a_out_err), 32'(bs_err[i-1]));
            end
        end
        a_in_valid = 1'b0;
        step();
        check({tag, "_drained"}, 32'(a_out_valid), 32'd0);
    endtask

    // Scoreboard for the wide build.
    typedef struct {
        logic [4:0] dat;
        logic       err;
        int         cyc;
        int         stalls;
    } beat_t;
    beat_t sb[$];

    initial begin
        beat_t bt;
        int    stalls;
        bit    pend;
        int unsigned s;

        a_in_valid = 1'b0; a_in_sel = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_sel = '0; b_out_ready = 1'b0; b_in_data = '0;
        for (int k = 0; k < 10; k++) a_in_data[k*8 +: 8] = 8'h10 + 8'(k);

        // Reset state.
        step(); step();
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_out_data", 32'(a_out_data), 32'd0);
        check("rst_out_err", 32'(a_out_err), 32'd0);
        check("rst_occ", 32'(a_occ), 32'd0);
        check("rst_in_ready_or0", 32'(a_in_ready), 32'd1);
        a_out_ready = 1'b1;
        #1;
        check("rst_in_ready_or1", 32'(a_in_ready), 32'd1);
        check("rst_b_occ", 32'(b_occ), 32'd0);
        rst_n = 1'b1;
        step();

        // 1: sel 0..9 back-to-back.
        for (int i = 0; i < 10; i++) begin
            bs_sel[i] = i; bs_dat[i] = 8'h10 + 8'(i); bs_err[i] = 1'b0;
        end
        burst("t1", 10);

        // 2: out-of-range selects around an in-range one.
        bs_sel[0] = 10; bs_dat[0] = 8'h00; bs_err[0] = 1'b1;
        bs_sel[1] = 3;  bs_dat[1] = 8'h13; bs_err[1] = 1'b0;
        bs_sel[2] = 15; bs_dat[2] = 8'h00; bs_err[2] = 1'b1;
        burst("t2", 3);

        // 3: backpressure with sel 1,2,3.
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_sel = 4'd1; step();
        a_in_sel = 4'd2; step();
        a_in_sel = 4'd3; #1;
        check("t3_occ_full", 32'(a_occ), 32'd2);
        check("t3_in_ready_low", 32'(a_in_ready), 32'd0);
        check("t3_valid", 32'(a_out_valid), 32'd1);
        check("t3_data_held0", 32'(a_out_data), 32'h11);
        step();
        check("t3_data_held1", 32'(a_out_data), 32'h11);
        check("t3_occ_held", 32'(a_occ), 32'd2);
        a_out_ready = 1'b1;
        step();
        a_in_valid = 1'b0;
        check("t3_beat2", 32'(a_out_data), 32'h12);
        step();
        check("t3_beat3", 32'(a_out_data), 32'h13);
        check("t3_beat3_valid", 32'(a_out_valid), 32'd1);
        step();
        check("t3_empty", 32'(a_out_valid), 32'd0);

        // 4: bubble collapse.
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_sel = 4'd4; step();
        a_in_valid = 1'b0;
        check("t4_occ1", 32'(a_occ), 32'd1);
        step();
        check("t4_out_valid", 32'(a_out_valid), 32'd1);
        step(); step();
        check("t4_occ_idle", 32'(a_occ), 32'd1);
        check("t4_in_ready_idle", 32'(a_in_ready), 32'd1);
        a_in_valid = 1'b1; a_in_sel = 4'd5; step();
        a_in_valid = 1'b0;
        check("t4_occ2", 32'(a_occ), 32'd2);
        check("t4_in_ready_full", 32'(a_in_ready), 32'd0);
        check("t4_head", 32'(a_out_data), 32'h14);
        a_out_ready = 1'b1;
        step();
        check("t4_second", 32'(a_out_data), 32'h15);
        step();
        check("t4_empty", 32'(a_out_valid), 32'd0);

        // 5: asynchronous reset mid-stream.
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_sel = 4'd6; step();
        a_in_sel = 4'd7; step();
        a_in_valid = 1'b0;
        check("t5_occ_pre", 32'(a_occ), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("t5_valid_rst", 32'(a_out_valid), 32'd0);
        check("t5_occ_rst", 32'(a_occ), 32'd0);
        check("t5_data_rst", 32'(a_out_data), 32'd0);
        #2 rst_n = 1'b1;
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_no_stale", 32'(a_out_valid), 32'd0);
        end

        // 6: random valid/ready on the wide build.
        stalls = 0;
        pend = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!pend) begin
                b_in_valid = ($urandom_range(0, 3) != 0);
                b_in_sel = 6'($urandom_range(0, 45));
                for (int k = 0; k < 37; k++) b_in_data[k*5 +: 5] = 5'($urandom);
            end
            b_out_ready = (cyc < 60 || cyc >= 590) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (cyc >= 580) b_in_valid = pend;
            @(negedge clk);
            if (b_out_valid && b_out_ready) begin
                check("t6_have_beat", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    bt = sb.pop_front();
                    check("t6_data", 32'(b_out_data), 32'(bt.dat));
                    check("t6_err", 32'(b_out_err), 32'(bt.err));
                    if (bt.stalls == stalls) check("t6_latency", 32'(cyc - bt.cyc), 32'd6);
                end
            end
            if (b_out_valid && !b_out_ready) stalls++;
            if (b_in_valid && b_in_ready) begin
                s = b_in_sel;
                bt.dat = (s < 37) ? b_in_data[s*5 +: 5] : 5'd0;
                bt.err = (s >= 37);
                bt.cyc = cyc;
                bt.stalls = stalls;
                sb.push_back(bt);
                pend = 1'b0;
            end else begin
                pend = b_in_valid;
            end
            @(posedge clk);
            #1;
        end
        b_in_valid = 1'b0;
        b_out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (b_out_valid) begin
                check("t6_drain_have", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    bt = sb.pop_front();
                    check("t6_drain_data", 32'(b_out_data), 32'(bt.dat));
                end
            end
        end
        check("t6_scoreboard_empty", 32'(sb.size()), 32'd0);
        check("t6_occ_idle", 32'(b_occ), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_pipeline_stream.md
Name: mux_pipeline_stream

Overview:
- Streaming N:1 multiplexer built as a registered radix-R tree, with a valid/ready handshake on both sides.
- Each transfer carries its own select value, so every output is one complete (data, sel) pair. Full backpressure, bubble collapsing, no data loss.
- Successor to the fixed-latency pipeline mux, for datapaths that need flow control and out-of-range select detection.

Parameters:
WIDTH, 8, bits per input channel
INPUT_COUNT, 10, number of input channels (>=2)
RADIX, 4, inputs per tree node; power of 2, >=2
SEL_W, derived = $clog2(INPUT_COUNT), select width
RB, derived = $clog2(RADIX), select bits consumed per level
LEVELS, derived = ceil(SEL_W/RB), number of registered tree levels (= latency)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
in_sel  in  SEL_W  channel select for this beat
in_data  in  WIDTH*INPUT_COUNT  channel k at [k*WIDTH +: WIDTH]
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat
out_data  out  WIDTH  selected channel
out_err  out  1  beat's in_sel was >= INPUT_COUNT
occupancy  out  $clog2(LEVELS+1)  number of valid stages in flight

Behaviour:
- Reset: asynchronous on rst_n low.
  - Clears every stage valid bit, data register, sel register and err bit.
  - out_valid=0, out_data=0, out_err=0, occupancy=0. in_ready=1 while out_ready is at any level (all stages empty).
  - Reset mid-stream discards all in-flight beats; no partial output after release.
- Tree structure: level k (k=0..LEVELS-1) holds ceil(INPUT_COUNT/RADIX^(k+1)) nodes.
  - Each node picks one of RADIX children using sel bits [k*RB +: RB], LSB group first.
  - Missing children (index past the last real source) read as zero.
  - Each level's node outputs are registered together with: the stage valid bit, the remaining sel bits, and the err flag.
- Error flag: err is computed at stage 0 as (in_sel >= INPUT_COUNT). When err=1 the final data is forced to 0.
- Advance rule (per stage, combinational back-chain):
  - en[LEVELS-1] = !v[LEVELS-1] | out_ready.
  - en[k] = !v[k] | en[k+1].
  - in_ready = en[0].
  - Stage k loads when en[k] is high: stage 0 loads (in_valid, tree level 0, in_sel, err); stage k>0 loads from stage k-1.
  - When a stage loads from an upstream stage that is invalid, its valid bit clears, so bubbles collapse.
  - When en[k] is low, stage k holds all of its contents.
- Outputs: out_valid = v[LEVELS-1]; out_data and out_err come from the last stage.
  - A transfer occurs when out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_data and out_err are stable.
- Latency and throughput:
  - Exactly LEVELS cycles from input handshake to out_valid, with no stalls.
  - 1 beat/cycle sustained when out_ready stays high.
  - Beat order is preserved.
- Occupancy: count of set stage valid bits, registered, updated every cycle.
- Simultaneous events:
  - A full pipe with out_ready=1 accepts a new beat in the same cycle.
  - in_valid=1 with in_ready=0 means the beat is not taken; the source must hold it.
- LEVELS=1 (e.g. INPUT_COUNT<=RADIX): single registered stage, same rules apply.
- in_data changes after the handshake have no effect on beats already in flight.

Test Plan:
1. Defaults, channel k holds 8'h10+k; send sel=0..9 back-to-back, out_ready=1 -> first out_valid 2 cycles after the first accept; outputs 8'h10..8'h19 on consecutive cycles; out_err=0 throughout.
2. Out-of-range selects sel=10,15 -> out_data=0 and out_err=1 for those beats; the surrounding sel=3 beat gives 8'h13 with out_err=0.
3. Backpressure: fill with sel=1,2,3 and hold out_ready=0 -> occupancy=2, in_ready=0, out_data=8'h11 held stable; release -> 8'h11, 8'h12, 8'h13 in order, none lost or duplicated.
4. Bubble collapse: send one beat, idle 3 cycles, hold out_ready=0, then send a second beat -> occupancy reaches 2; in_ready=1 until both stages are valid.
5. Reset mid-stream: assert rst_n low asynchronously between edges with occupancy=2 -> out_valid=0 and occupancy=0 immediately; no stale beat appears after release.
6. Randomised valid/ready, WIDTH=5, INPUT_COUNT=37, RADIX=2 (LEVELS=6) -> output stream matches a scoreboard of in_data[sel]; latency is exactly 6 whenever there are no stalls.
